// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - multi-cycle ALU controller: decode, execute wait, flag capture, branch resolve
//
// Purpose: accepts a decoded RV32I instruction, drives the 3-bit ALU control code, holds it
// for EXEC_CYCLES cycles, captures the ALU result and {N,Z,V,C} flags, resolves branch
// conditions, and returns everything through a valid/ready response port.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_valid/instr_ready       instruction handshake (ready only in IDLE)
//   opcode, funct3, funct7b5      decoded instruction fields
//   alu_ctrl                      ALU control (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   alu_res, alu_n/z/v/c          ALU result and flags
//   rsp_valid/rsp_ready           response handshake
//   rsp_result, rsp_taken, rsp_illegal, rsp_flags   response payload, flags as {N,Z,V,C}

module alu_ctrl_fsm #(
    parameter int XLEN        = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_n,
    input  logic            alu_z,
    input  logic            alu_v,
    input  logic            alu_c,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_taken,
    output logic            rsp_illegal,
    output logic [3:0]      rsp_flags
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [2:0]        f3_q, f3_d;
    logic              f7_q, f7_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;

    logic [2:0]        dec_ctrl;
    logic              dec_ill;
    logic              br_cond;

    // Decode from the latched fields; dec_ctrl is only meaningful when dec_ill is low.
    always_comb begin
        dec_ctrl = ctrl_q;
        dec_ill  = 1'b0;
        case (op_q)
            OP_R, OP_I: begin
                case (f3_q)
                    3'b000:  dec_ctrl = (op_q == OP_R && f7_q) ? 3'b001 : 3'b000;
                    3'b010:  dec_ctrl = 3'b101;
                    3'b110:  dec_ctrl = 3'b011;
                    3'b111:  dec_ctrl = 3'b010;
                    default: dec_ill  = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: dec_ctrl = 3'b000;
            OP_BRANCH: begin
                dec_ctrl = 3'b001;
                dec_ill  = (f3_q == 3'b010) || (f3_q == 3'b011);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Branch condition from the flags of the subtraction a - b.
    always_comb begin
        br_cond = 1'b0;
        case (f3_q)
            3'b000:  br_cond = alu_z;
            3'b001:  br_cond = ~alu_z;
            3'b100:  br_cond = alu_n ^ alu_v;
            3'b101:  br_cond = ~(alu_n ^ alu_v);
            3'b110:  br_cond = ~alu_c;
            3'b111:  br_cond = alu_c;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        f3_d      = f3_q;
        f7_d      = f7_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        flags_d   = flags_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = opcode;
                    f3_d    = funct3;
                    f7_d    = funct7b5;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_ill) begin
                    // Illegal instructions skip the ALU entirely and keep alu_ctrl as it was.
                    result_d  = '0;
                    flags_d   = 4'b0000;
                    taken_d   = 1'b0;
                    illegal_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    ctrl_d  = dec_ctrl;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    result_d  = alu_res;
                    flags_d   = {alu_n, alu_z, alu_v, alu_c};
                    taken_d   = (op_q == OP_BRANCH) && br_cond;
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= 1'b0;
            ctrl_q    <= 3'b000;
            cnt_q     <= '0;
            result_q  <= '0;
            flags_q   <= 4'b0000;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            f7_q      <= f7_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign alu_ctrl    = ctrl_q;
    assign rsp_result  = result_q;
    assign rsp_flags   = flags_q;
    assign rsp_taken   = taken_q;
    assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb/tb_alu_ctrl_fsm.sv - randomized self-checking bench for alu_ctrl_fsm with a stand-in ALU

module tb_alu_ctrl_fsm;

    localparam int XLEN = 32;
    localparam int EC   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] alu_res;
    logic            alu_n, alu_z, alu_v, alu_c;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_taken;
    logic            rsp_illegal;
    logic [3:0]      rsp_flags;

    logic [31:0]     alu_a, alu_b;
    logic [31:0]     bop;
    logic [32:0]     sum;

    int              n_checks = 0;
    int              n_pass   = 0;
    logic [2:0]      last_ctrl;

    always #5 clk = ~clk;

    alu_ctrl_fsm #(.XLEN(XLEN), .EXEC_CYCLES(EC)) u_dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .alu_ctrl(alu_ctrl), .alu_res(alu_res),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_taken(rsp_taken),
        .rsp_illegal(rsp_illegal), .rsp_flags(rsp_flags)
    );

    // Stand-in for the team ALU: adder-based add/sub with carry-out and overflow flags.
    always_comb begin
        bop     = (alu_ctrl == 3'b001) ? ~alu_b : alu_b;
        sum     = {1'b0, alu_a} + {1'b0, bop} + {32'd0, (alu_ctrl == 3'b001)};
        alu_res = 32'd0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (alu_ctrl)
            3'b000, 3'b001: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (alu_a[31] == bop[31]) && (sum[31] != alu_a[31]);
            end
            3'b010:  alu_res = alu_a & alu_b;
            3'b011:  alu_res = alu_a | alu_b;
            3'b101:  alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_res = 32'd0;
        endcase
        alu_n = alu_res[31];
        alu_z = (alu_res == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                output logic ill, output logic [2:0] c);
        ill = 1'b0;
        c   = 3'b000;
        if (op == 7'h33 || op == 7'h13) begin
            if (f3 == 3'd0)      c = (op == 7'h33 && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'd2) c = 3'b101;
            else if (f3 == 3'd6) c = 3'b011;
            else if (f3 == 3'd7) c = 3'b010;
            else                 ill = 1'b1;
        end else if (op == 7'h03 || op == 7'h23) begin
            c = 3'b000;
        end else if (op == 7'h63) begin
            c   = 3'b001;
            ill = (f3 == 3'd2 || f3 == 3'd3);
        end else begin
            ill = 1'b1;
        end
    endtask

    // Expected response computed with plain integer arithmetic on the operands.
    task automatic model_exec(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] c,
                              input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] res, output logic [3:0] fl, output logic tk);
        longint sa, sb, s;
        logic   v, cy;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v  = 1'b0;
        cy = 1'b0;
        case (c)
            3'b000: begin
                res = a + b;
                s   = sa + sb;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                cy  = (longint'(a) + longint'(b)) >= 64'sh1_0000_0000;
            end
            3'b001: begin
                res = a - b;
                s   = sa - sb;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                cy  = (a >= b);
            end
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            default: res = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        fl = {res[31], (res == 32'd0), v, cy};
        tk = 1'b0;
        if (op == 7'h63) begin
            case (f3)
                3'd0:    tk = (a == b);
                3'd1:    tk = (a != b);
                3'd4:    tk = (sa < sb);
                3'd5:    tk = (sa >= sb);
                3'd6:    tk = (a < b);
                default: tk = (a >= b);
            endcase
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b, input int hold);
        logic        ill, tk;
        logic [2:0]  c;
        logic [31:0] er;
        logic [3:0]  ef;
        logic [37:0] snap;
        int          n;
        model_decode(op, f3, f7, ill, c);
        if (ill) begin
            er = 32'd0; ef = 4'd0; tk = 1'b0;
        end else begin
            last_ctrl = c;
            model_exec(op, f3, c, a, b, er, ef, tk);
        end

        @(negedge clk);
        alu_a = a; alu_b = b;
        opcode = op; funct3 = f3; funct7b5 = f7;
        instr_valid = 1'b1;
        check("idle_ready", instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            check("busy_ready", instr_ready, 0);
            instr_valid = 1'($urandom);
            opcode      = 7'($urandom);
            funct3      = 3'($urandom);
            funct7b5    = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        instr_valid = 1'b0;
        check("latency", n, ill ? 1 : 1 + EC);
        check("alu_ctrl", alu_ctrl, last_ctrl);
        check("result", rsp_result, er);
        check("flags", rsp_flags, ef);
        check("taken", rsp_taken, tk);
        check("illegal", rsp_illegal, ill);
        check("resp_ready", instr_ready, 0);

        snap = {rsp_result, rsp_flags, rsp_taken, rsp_illegal};
        for (int i = 0; i < hold; i++) begin
            instr_valid = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_stable", ({rsp_result, rsp_flags, rsp_taken, rsp_illegal} == snap), 1);
            check("hold_ready", instr_ready, 0);
        end
        instr_valid = 1'b0;
        rsp_ready   = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("done_valid", rsp_valid, 0);
        check("done_ready", instr_ready, 1);
    endtask

    initial begin
        logic [6:0]  rop;
        logic [31:0] ra, rb;
        int          sel;
        rst = 1'b1; instr_valid = 1'b0; rsp_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7b5 = 1'b0; alu_a = '0; alu_b = '0;
        last_ctrl = 3'b000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", instr_ready, 1);
        check("rst_valid", rsp_valid, 0);
        check("rst_ctrl", alu_ctrl, 0);
        check("rst_result", rsp_result, 0);
        check("rst_flags", rsp_flags, 0);

        run_instr(7'h33, 3'd0, 1'b1, 32'd5, 32'd7, 0);
        check("sub_result_const", rsp_result, 32'hFFFFFFFE);
        run_instr(7'h63, 3'd0, 1'b0, 32'd3, 32'd3, 0);
        run_instr(7'h63, 3'd1, 1'b0, 32'd3, 32'd3, 0);
        run_instr(7'h63, 3'd4, 1'b0, 32'hFFFFFFFF, 32'd1, 0);
        run_instr(7'h63, 3'd6, 1'b0, 32'hFFFFFFFF, 32'd1, 0);
        run_instr(7'h63, 3'd7, 1'b0, 32'hFFFFFFFF, 32'd1, 0);
        run_instr(7'h33, 3'd0, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 0);
        run_instr(7'h63, 3'd4, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 0);
        run_instr(7'h7F, 3'd0, 1'b0, 32'd1, 32'd2, 0);
        run_instr(7'h13, 3'd6, 1'b0, 32'h0F0F0000, 32'h000000F0, 5);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0: rop = 7'h33;
                1: rop = 7'h13;
                2: rop = 7'h03;
                3: rop = 7'h23;
                4, 5: rop = 7'h63;
                default: rop = 7'($urandom);
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            run_instr(rop, 3'($urandom), 1'($urandom), ra, rb, $urandom_range(0, 3));
        end

        // Reset in the middle of EXEC drops the response.
        @(negedge clk);
        alu_a = 32'd9; alu_b = 32'd4;
        opcode = 7'h33; funct3 = 3'd0; funct7b5 = 1'b1;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_ctrl = 3'b000;
        check("midrst_valid", rsp_valid, 0);
        check("midrst_ready", instr_ready, 1);
        check("midrst_ctrl", alu_ctrl, 0);
        check("midrst_result", rsp_result, 0);
        check("midrst_flags", rsp_flags, 0);
        check("midrst_taken", rsp_taken, 0);
        check("midrst_illegal", rsp_illegal, 0);
        run_instr(7'h33, 3'd7, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
